// File: rtl/mem_arbiter.sv
// Round-robin share of the single Data_Memory line port between two cache controllers, one whole transaction per grant.
// Grant is 1 cycle after request; the winner's request is latched until the memory ack, and requesters simply hold enable until their ack.
module mem_arbiter #(
   parameter int DATA_W = 256,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,

   input  logic              m0_enable_i,
   input  logic              m0_write_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_data_i,
   output logic              m0_ack_o,
   output logic [DATA_W-1:0] m0_data_o,

   input  logic              m1_enable_i,
   input  logic              m1_write_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_data_i,
   output logic              m1_ack_o,
   output logic [DATA_W-1:0] m1_data_o,

   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_data_i,

   output logic              busy_o,
   output logic              owner_o,
   output logic [CNT_W-1:0]  m0_count_o,
   output logic [CNT_W-1:0]  m1_count_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                enable_q, enable_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                busy_q, busy_d;
   logic [CNT_W-1:0]    cnt0_q, cnt0_d;
   logic [CNT_W-1:0]    cnt1_q, cnt1_d;

   logic                grant_id;
   logic                ack_take;

   // On a tie the previous owner yields; owner resets to 1 so m0 wins first.
   always_comb begin
      grant_id = 1'b0;
      if (m0_enable_i && m1_enable_i) begin
         grant_id = ~owner_q;
      end else begin
         grant_id = m1_enable_i;
      end
   end

   assign ack_take = (state_q == BUSY) && mem_ack_i;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      enable_d = enable_q;
      write_d  = write_q;
      addr_d   = addr_q;
      data_d   = data_q;
      busy_d   = busy_q;
      cnt0_d   = cnt0_q;
      cnt1_d   = cnt1_q;

      case (state_q)
         IDLE: begin
            if (m0_enable_i || m1_enable_i) begin
               owner_d  = grant_id;
               write_d  = grant_id ? m1_write_i : m0_write_i;
               addr_d   = grant_id ? m1_addr_i  : m0_addr_i;
               data_d   = grant_id ? m1_data_i  : m0_data_i;
               enable_d = 1'b1;
               busy_d   = 1'b1;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            if (mem_ack_i) begin
               enable_d = 1'b0;
               busy_d   = 1'b0;
               state_d  = GAP;
               if (owner_q) begin
                  cnt1_d = cnt1_q + CNT_W'(1);
               end else begin
                  cnt0_d = cnt0_q + CNT_W'(1);
               end
            end
         end
         GAP: begin
            // Requests are ignored here so the finished owner can drop enable.
            state_d = IDLE;
         end
         default: begin
            state_d  = IDLE;
            enable_d = 1'b0;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         owner_q  <= 1'b1;
         enable_q <= 1'b0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         busy_q   <= 1'b0;
         cnt0_q   <= '0;
         cnt1_q   <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         enable_q <= enable_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         cnt0_q   <= cnt0_d;
         cnt1_q   <= cnt1_d;
      end
   end

   assign mem_enable_o = enable_q;
   assign mem_write_o  = write_q;
   assign mem_addr_o   = addr_q;
   assign mem_data_o   = data_q;

   // Ack is forwarded combinationally and only while a grant is live.
   assign m0_ack_o  = ack_take & ~owner_q;
   assign m1_ack_o  = ack_take &  owner_q;
   assign m0_data_o = mem_data_i;
   assign m1_data_o = mem_data_i;

   assign busy_o     = busy_q;
   assign owner_o    = owner_q;
   assign m0_count_o = cnt0_q;
   assign m1_count_o = cnt1_q;

   a_enable_tracks_busy: assert property (@(posedge clk_i) disable iff (rst_i)
      enable_q == (state_q == BUSY));

   a_request_held: assert property (@(posedge clk_i) disable iff (rst_i)
      (state_q == BUSY && !mem_ack_i) |=>
         (state_q == BUSY && $stable(addr_q) && $stable(data_q) && $stable(write_q)));

   a_gap_then_idle: assert property (@(posedge clk_i) disable iff (rst_i)
      (state_q == GAP) |=> (state_q == IDLE && !enable_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: behavioural Data_Memory responder plus a scoreboard fed by the requester drivers.
module tb_mem_arbiter;
   localparam int DW = 256;
   localparam int AW = 32;
   localparam int CW = 16;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } txn_t;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          m0_enable_i, m0_write_i, m0_ack_o;
   logic [AW-1:0] m0_addr_i;
   logic [DW-1:0] m0_data_i, m0_data_o;
   logic          m1_enable_i, m1_write_i, m1_ack_o;
   logic [AW-1:0] m1_addr_i;
   logic [DW-1:0] m1_data_i, m1_data_o;
   logic          mem_enable_o, mem_write_o, mem_ack_i;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_data_o, mem_data_i;
   logic          busy_o, owner_o;
   logic [CW-1:0] m0_count_o, m1_count_o;

   logic          resp_ack, force_ack;
   assign mem_ack_i = resp_ack | force_ack;

   always #5 clk_i = ~clk_i;

   mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
      .m0_data_i(m0_data_i), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
      .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
      .m1_data_i(m1_data_i), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
      .busy_o(busy_o), .owner_o(owner_o), .m0_count_o(m0_count_o), .m1_count_o(m1_count_o)
   );

   localparam logic [DW-1:0] INIT_LINE = {16{16'hECFA}};
   localparam logic [DW-1:0] A5_LINE   = {32{8'hA5}};

   logic [DW-1:0] dmem    [0:63];
   logic [DW-1:0] ref_mem [0:63];
   txn_t          q0[$];
   txn_t          q1[$];
   int            n_cmp = 0;
   int            n_err = 0;
   bit            mon_en = 1'b0;
   bit            resp_en = 1'b1;
   int            resp_min = 1;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_line();
      logic [DW-1:0] l;
      for (int i = 0; i < DW / 32; i++) l[i*32 +: 32] = $urandom();
      return l;
   endfunction

   // Data_Memory: acks 1..4 cycles after enable, line index is addr[10:5].
   initial begin : responder
      int lat;
      lat = 0;
      resp_ack = 1'b0;
      mem_data_i = '0;
      for (int i = 0; i < 64; i++) dmem[i] = INIT_LINE;
      forever begin
         @(posedge clk_i);
         #1;
         if (resp_en) begin
            resp_ack = 1'b0;
            mem_data_i = rand_line();
            if (mem_enable_o) begin
               if (lat == 0) lat = $urandom_range(4, resp_min);
               lat--;
               if (lat == 0) begin
                  resp_ack = 1'b1;
                  if (mem_write_o) dmem[mem_addr_o[10:5]] = mem_data_o;
                  else mem_data_i = dmem[mem_addr_o[10:5]];
               end
            end else begin
               lat = 0;
            end
         end
      end
   end

   // Scoreboard: expected grant order from the round-robin rule, expected read data from a line-array model.
   initial begin : monitor
      bit   prev_en, p0, p1, in_txn, gap_chk, last_own, own;
      int   cnt0, cnt1;
      txn_t cur;
      prev_en = 0; p0 = 0; p1 = 0; in_txn = 0; gap_chk = 0; last_own = 1; cnt0 = 0; cnt1 = 0;
      for (int i = 0; i < 64; i++) ref_mem[i] = INIT_LINE;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            last_own = 1; cnt0 = 0; cnt1 = 0; in_txn = 0; gap_chk = 0;
            q0.delete();
            q1.delete();
         end else if (mon_en) begin
            if (gap_chk) begin
               chk("gap_mem_enable", DW'(mem_enable_o), '0);
               chk("gap_busy", DW'(busy_o), '0);
               chk("count_m0", DW'(m0_count_o), DW'(cnt0[CW-1:0]));
               chk("count_m1", DW'(m1_count_o), DW'(cnt1[CW-1:0]));
               gap_chk = 0;
            end
            if (mem_enable_o && !prev_en) begin
               own = (p0 && p1) ? !last_own : p1;
               chk("grant_owner", DW'(owner_o), DW'(own));
               chk("grant_busy", DW'(busy_o), DW'(1));
               if ((own && q1.size() == 0) || (!own && q0.size() == 0)) begin
                  chk("grant_has_request", DW'(0), DW'(1));
               end else begin
                  cur = own ? q1[0] : q0[0];
                  chk("grant_addr", DW'(mem_addr_o), DW'(cur.addr));
                  chk("grant_write", DW'(mem_write_o), DW'(cur.wr));
                  chk("grant_data", mem_data_o, cur.data);
                  in_txn = 1;
                  last_own = own;
               end
            end else if (in_txn && mem_enable_o) begin
               chk("hold_addr", DW'(mem_addr_o), DW'(cur.addr));
               chk("hold_write", DW'(mem_write_o), DW'(cur.wr));
               chk("hold_data", mem_data_o, cur.data);
            end
            if (in_txn && mem_ack_i) begin
               chk("ack_owner", DW'(last_own ? m1_ack_o : m0_ack_o), DW'(1));
               chk("ack_other_quiet", DW'(last_own ? m0_ack_o : m1_ack_o), DW'(0));
               if (!cur.wr) chk("read_data", last_own ? m1_data_o : m0_data_o, ref_mem[cur.addr[10:5]]);
               else ref_mem[cur.addr[10:5]] = cur.data;
               if (last_own) begin
                  void'(q1.pop_front());
                  cnt1++;
               end else begin
                  void'(q0.pop_front());
                  cnt0++;
               end
               in_txn = 0;
               gap_chk = 1;
            end
         end
         prev_en = mem_enable_o;
         p0 = m0_enable_i;
         p1 = m1_enable_i;
      end
   end

   // Called just after a rising edge; returns just after the edge that closes the ack cycle.
   task automatic drive_txn(input bit who, input bit wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input bit scramble);
      txn_t t;
      bit   got, scr;
      t.wr = wr; t.addr = addr; t.data = data;
      if (!who) begin
         m0_write_i = wr; m0_addr_i = addr; m0_data_i = data; m0_enable_i = 1'b1;
         q0.push_back(t);
      end else begin
         m1_write_i = wr; m1_addr_i = addr; m1_data_i = data; m1_enable_i = 1'b1;
         q1.push_back(t);
      end
      got = 0;
      scr = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk_i);
         if (who ? m1_ack_o : m0_ack_o) begin
            got = 1;
         end else if (scramble && !scr && mem_enable_o && owner_o == who) begin
            if (!who) begin m0_addr_i = ~addr; m0_data_i = ~data; end
            else      begin m1_addr_i = ~addr; m1_data_i = ~data; end
            scr = 1;
         end
      end
      if (!got) chk("ack_timeout", DW'(0), DW'(1));
      @(posedge clk_i);
      #1;
      if (!who) m0_enable_i = 1'b0;
      else      m1_enable_i = 1'b0;
   endtask

   task automatic run_req(input bit who, input int n, input int max_idle);
      int idle;
      for (int k = 0; k < n; k++) begin
         drive_txn(who, 1'($urandom_range(1, 0)), AW'($urandom_range(63, 0)) << 5, rand_line(), 1'b0);
         idle = $urandom_range(max_idle, 0);
         if (idle > 0) begin
            repeat (idle) @(posedge clk_i);
            #1;
         end
      end
   endtask

   task automatic do_reset();
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      rst_i = 1'b1; force_ack = 1'b0;
      m0_enable_i = 0; m0_write_i = 0; m0_addr_i = '0; m0_data_i = '0;
      m1_enable_i = 0; m1_write_i = 0; m1_addr_i = '0; m1_data_i = '0;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;

      @(negedge clk_i);
      chk("rst_mem_enable", DW'(mem_enable_o), '0);
      chk("rst_mem_write", DW'(mem_write_o), '0);
      chk("rst_mem_addr", DW'(mem_addr_o), '0);
      chk("rst_mem_data", mem_data_o, '0);
      chk("rst_busy", DW'(busy_o), '0);
      chk("rst_owner", DW'(owner_o), DW'(1));
      chk("rst_acks", DW'({m0_ack_o, m1_ack_o}), '0);
      chk("rst_count_m0", DW'(m0_count_o), '0);
      chk("rst_count_m1", DW'(m1_count_o), '0);
      mon_en = 1'b1;

      // Single m0 read of 0x40: one-cycle grant latency, then gap.
      @(posedge clk_i);
      #1;
      fork
         drive_txn(1'b0, 1'b0, 32'h40, '0, 1'b0);
         begin
            @(negedge clk_i);
            chk("t1_enable_before_grant", DW'(mem_enable_o), '0);
            @(negedge clk_i);
            chk("t1_enable_latency", DW'(mem_enable_o), DW'(1));
            chk("t1_addr", DW'(mem_addr_o), DW'(32'h40));
         end
      join
      @(negedge clk_i);
      chk("t1_count_m0", DW'(m0_count_o), DW'(1));
      chk("t1_gap_enable", DW'(mem_enable_o), '0);

      // Simultaneous requests after reset: m0 first, then m1.
      do_reset();
      fork
         drive_txn(1'b0, 1'b0, 32'h000, '0, 1'b0);
         drive_txn(1'b1, 1'b0, 32'h200, '0, 1'b0);
      join

      // Continuous re-request: strict alternation, three each.
      do_reset();
      fork
         run_req(1'b0, 3, 0);
         run_req(1'b1, 3, 0);
      join
      @(negedge clk_i);
      chk("t4_count_m0", DW'(m0_count_o), DW'(3));
      chk("t4_count_m1", DW'(m1_count_o), DW'(3));

      // m1 write with inputs changed mid-transaction; memory must get the latched line.
      resp_min = 3;
      @(posedge clk_i);
      #1;
      drive_txn(1'b1, 1'b1, 32'h420, A5_LINE, 1'b1);
      resp_min = 1;
      chk("t5_line33", dmem[33], A5_LINE);

      // Random contention.
      do_reset();
      fork
         run_req(1'b0, 30, 3);
         run_req(1'b1, 30, 3);
      join

      // Reset 3 cycles into a BUSY m1 read; the late ack must be ignored.
      mon_en = 1'b0;
      resp_en = 1'b0;
      @(posedge clk_i);
      #1;
      m1_write_i = 1'b0; m1_addr_i = 32'h100; m1_enable_i = 1'b1;
      for (int i = 0; i < 20 && !mem_enable_o; i++) @(negedge clk_i);
      chk("t7_busy_before_reset", DW'(busy_o), DW'(1));
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      m1_enable_i = 1'b0;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      chk("t7_enable", DW'(mem_enable_o), '0);
      chk("t7_busy", DW'(busy_o), '0);
      chk("t7_owner", DW'(owner_o), DW'(1));
      chk("t7_counts", DW'({m0_count_o, m1_count_o}), '0);
      force_ack = 1'b1;
      @(negedge clk_i);
      chk("t7_late_ack_quiet", DW'({m0_ack_o, m1_ack_o}), '0);
      @(posedge clk_i);
      #1 force_ack = 1'b0;
      @(negedge clk_i);
      chk("t7_counts_after_ack", DW'({m0_count_o, m1_count_o}), '0);

      // Stray ack held high in IDLE with no requests.
      @(posedge clk_i);
      #1 force_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("t8_acks_quiet", DW'({m0_ack_o, m1_ack_o}), '0);
         chk("t8_idle", DW'({busy_o, mem_enable_o}), '0);
      end
      @(posedge clk_i);
      #1 force_ack = 1'b0;
      @(negedge clk_i);
      chk("t8_counts", DW'({m0_count_o, m1_count_o}), '0);

      // Still in IDLE: a fresh request is granted after one cycle.
      @(posedge clk_i);
      #1 m0_enable_i = 1'b1; m0_addr_i = 32'h80;
      @(negedge clk_i);
      @(negedge clk_i);
      chk("t8_regrant", DW'({mem_enable_o, owner_o}), DW'(2'b10));
      m0_enable_i = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter that shares the single off-chip Data_Memory port (256-bit line, enable/write/ack handshake) between the instruction-side cache controller (m0) and the data cache controller (m1). It sits between the CPU's cache controllers and Data_Memory and replaces the direct dcache-to-memory wiring. It grants one whole transaction at a time, round-robin, and latches the winner's request so memory sees stable inputs until ack. It also keeps per-requester completed-transaction counters for bench visibility.

Parameters:
DATA_W, 256, memory line width in bits
ADDR_W, 32, memory address width in bits
CNT_W, 16, width of per-requester transaction counters

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
m0_enable_i  in  1  requester 0 transaction request, held until m0_ack_o
m0_write_i  in  1  requester 0 write (1) / read (0)
m0_addr_i  in  ADDR_W  requester 0 byte address
m0_data_i  in  DATA_W  requester 0 write line
m0_ack_o  out  1  requester 0 completion pulse
m0_data_o  out  DATA_W  read line to requester 0
m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_ack_o, m1_data_o: same as m0, for requester 1
mem_enable_o  out  1  to Data_Memory enable_i
mem_write_o  out  1  to Data_Memory write_i
mem_addr_o  out  ADDR_W  to Data_Memory addr_i
mem_data_o  out  DATA_W  to Data_Memory data_i
mem_ack_i  in  1  from Data_Memory ack_o
mem_data_i  in  DATA_W  from Data_Memory data_o
busy_o  out  1  high while the memory port is owned
owner_o  out  1  current or most recent owner (0 = m0, 1 = m1)
m0_count_o  out  CNT_W  completed m0 transactions, wraps at 2^CNT_W
m1_count_o  out  CNT_W  completed m1 transactions, wraps at 2^CNT_W

Behaviour:
- Reset values: state IDLE; mem_enable_o, mem_write_o, busy_o, m0_ack_o, m1_ack_o = 0; mem_addr_o, mem_data_o, counters = 0; owner_o = 1, so m0 wins first.
- States: IDLE, BUSY, GAP.
- IDLE:
  - If exactly one enable is high, grant that requester.
  - If both are high, grant the requester that is not owner_o (round-robin).
  - On grant, at the clock edge: register owner_o; latch write, addr and data into the mem_* output registers; set mem_enable_o = 1 and busy_o = 1; go to BUSY.
  - Arbitration latency is 1 cycle from request to mem_enable_o.
- BUSY:
  - mem_* outputs are held constant, independent of later requester input changes.
  - When mem_ack_i = 1: the owner's ack is driven combinationally in the same cycle (mx_ack_o = mem_ack_i & (owner_o == x)); the other ack stays 0.
  - At that same edge: mem_enable_o <= 0, the owner's counter increments, go to GAP.
- GAP:
  - One cycle with mem_enable_o = 0 and all requests ignored, so the owner can drop its enable.
  - busy_o <= 0 on entry to GAP; next state IDLE.
  - Minimum spacing between transactions: mem_enable_o low for at least 1 cycle.
- m0_data_o and m1_data_o both equal mem_data_i at all times; data is valid only when the matching ack is high.
- mem_ack_i outside BUSY is ignored: no ack out, no counter change.
- A requester dropping its enable during BUSY is illegal. The arbiter still completes the latched transaction and forwards the ack.
- rst_i during BUSY or GAP: next cycle IDLE with all reset values. The in-flight memory transaction is abandoned and any later stray ack is ignored.
- Counters increment only on a BUSY-state ack and wrap from all-ones to 0.

Test Plan:
- Reset, then m0 read of 0x00000040 only:
  - mem_enable_o = 1 and mem_addr_o = 0x40 one cycle later.
  - On mem_ack_i, m0_ack_o = 1 with m0_data_o = ECFA repeated; m1_ack_o = 0.
  - m0_count_o = 1; mem_enable_o = 0 for the following cycle.
- Both request in the same cycle after reset (m0 addr 0x000, m1 addr 0x200):
  - m0 is granted first; after its ack plus the GAP cycle, m1 is granted.
  - mem_addr_o sequence is 0x000, then 0x200.
- Both requesters continuously re-request for 6 transactions:
  - owner_o sequence is 0,1,0,1,0,1; each counter ends at 3.
- m1 write to 0x420 with data 0xA5 repeated; m1 changes addr and data mid-BUSY:
  - mem_addr_o and mem_data_o keep the latched values until ack.
  - Data_Memory line 33 holds the A5 pattern.
- rst_i pulsed 3 cycles into a BUSY m1 read:
  - Next cycle mem_enable_o = 0, busy_o = 0, owner_o = 1, counters = 0.
  - The late memory ack produces no m0_ack_o or m1_ack_o.
- mem_ack_i forced high in IDLE with no requests:
  - No ack outputs, counters unchanged, state stays IDLE.
